// File: rtl/poly_nco_if.sv
// poly_nco_if: request/sample bundle between a poly_nco and its controller
interface poly_nco_if #(
  parameter int N_CH = 4,
  parameter int PHASE_W = 24,
  parameter int CODE_W = 10
);
  logic [N_CH*PHASE_W-1:0] fcw;
  logic [N_CH-1:0] ch_en;
  logic [2*N_CH-1:0] wave_sel;
  logic next_sample;
  logic ready;
  logic [CODE_W-1:0] code;
  logic code_valid;
  modport master (output fcw, ch_en, wave_sel, next_sample, input ready, code, code_valid);
  modport slave (input fcw, ch_en, wave_sel, next_sample, output ready, code, code_valid);
endinterface

// File: rtl/poly_nco.sv
// poly_nco: N_CH phase accumulators sharing one registered sine ROM, mixed to one offset-binary code; POLY_NCO_MULTI_WAVE_EN adds square/saw/triangle voices
module poly_nco #(
  parameter int N_CH = 4,
  parameter int PHASE_W = 24,
  parameter int LUT_AW = 8,
  parameter int CODE_W = 10
) (
  input logic clk,
  input logic rst,
  poly_nco_if.slave nco
);
  localparam int LG = $clog2(N_CH);
  localparam int KW = LG > 0 ? LG : 1;
  localparam int AW = CODE_W + LG;
  localparam logic [CODE_W-1:0] MID = CODE_W'(2**(CODE_W-1));
`ifdef POLY_NCO_MULTI_WAVE_EN
  localparam int TW = CODE_W > LUT_AW ? CODE_W : LUT_AW;
`else
  localparam int TW = LUT_AW;
`endif
  typedef enum logic [1:0] {IDLE, STEP, DRAIN, OUT} state_t;
  state_t r_state, w_next;
  logic [KW-1:0] r_k;
  logic [PHASE_W-1:0] r_phase [N_CH];
  logic [TW-1:0] r_top;
  logic r_en, r_add, r_valid;
  logic signed [AW-1:0] r_acc;
  logic [CODE_W-1:0] r_code;
  logic w_ready, w_step, w_last, w_out, w_chen;
  logic [PHASE_W-1:0] w_fcw, w_sum, w_cur;
  logic [CODE_W-1:0] w_rom [2**LUT_AW];
  logic [CODE_W-1:0] w_voice;
  logic signed [CODE_W-1:0] w_sv;
  logic signed [AW-1:0] w_mix, w_shr;

  function automatic logic [CODE_W-1:0] sine_at(input int a);
    real x;
    int v;
    x = (2.0 ** (CODE_W - 1) - 1.0) * $sin(2.0 * 3.14159265358979323846 * a / (2.0 ** LUT_AW));
    v = $rtoi($floor(x + 0.5));
    return CODE_W'(v + 2 ** (CODE_W - 1));
  endfunction

  for (genvar a = 0; a < 2**LUT_AW; a++) begin : g_rom
    localparam logic [CODE_W-1:0] V = sine_at(a);
    assign w_rom[a] = V;
  end

  assign w_fcw = nco.fcw[r_k*PHASE_W +: PHASE_W];
  assign w_chen = nco.ch_en[r_k];
  assign w_sum = r_phase[r_k] + w_fcw;
  assign w_cur = w_chen ? w_sum : r_phase[r_k];

`ifdef POLY_NCO_MULTI_WAVE_EN
  logic [1:0] r_sel;
  logic [CODE_W-1:0] w_tri;
  // voice lookup from the registered phase: sine ROM or one of the arithmetic shapes
  always_comb begin
    w_tri = {r_top[TW-2 -: CODE_W-1], 1'b0};
    w_voice = r_sel == 2'd0 ? w_rom[r_top[TW-1 -: LUT_AW]] :
              r_sel == 2'd1 ? (r_top[TW-1] ? '0 : '1) :
              r_sel == 2'd2 ? r_top[TW-1 -: CODE_W] :
              (r_top[TW-1] ? ~w_tri : w_tri);
  end
`else
  logic w_unused;
  assign w_unused = ^nco.wave_sel;
  assign w_voice = w_rom[r_top[TW-1 -: LUT_AW]];
`endif

  assign w_sv = {~w_voice[CODE_W-1], w_voice[CODE_W-2:0]};
  assign w_mix = r_en ? AW'(w_sv) : '0;
  assign w_shr = r_acc >>> LG;

  // state register
  always_ff @(posedge clk) r_state <= rst ? IDLE : w_next;

  // next state: one STEP per channel, then one cycle for the last ROM read and one to publish
  always_comb w_next = w_ready ? (nco.next_sample ? STEP : IDLE) :
                       w_step ? (w_last ? DRAIN : STEP) :
                       r_state == DRAIN ? OUT : IDLE;

  // state decodes
  always_comb begin
    w_ready = r_state == IDLE;
    w_step = r_state == STEP;
    w_out = r_state == OUT;
    w_last = r_k == KW'(N_CH - 1);
  end

  // phase stepping, voice pipeline and mix accumulation
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < N_CH; i++) r_phase[i] <= '0;
      r_k <= '0;
      r_top <= '0;
      r_en <= 1'b0;
      r_add <= 1'b0;
      r_acc <= '0;
      r_code <= MID;
      r_valid <= 1'b0;
`ifdef POLY_NCO_MULTI_WAVE_EN
      r_sel <= 2'd0;
`endif
    end else begin
      r_add <= w_step;
      r_valid <= w_out;
      r_k <= w_step ? r_k + 1'b1 : '0;
      if (w_step) begin
        if (w_chen) r_phase[r_k] <= w_sum;
        r_top <= w_cur[PHASE_W-1 -: TW];
        r_en <= w_chen;
`ifdef POLY_NCO_MULTI_WAVE_EN
        r_sel <= nco.wave_sel[2*r_k +: 2];
`endif
      end
      if (w_ready && nco.next_sample) r_acc <= '0;
      else if (r_add) r_acc <= r_acc + w_mix;
      if (w_out) r_code <= w_shr[CODE_W-1:0] + MID;
    end
  end

  assign nco.ready = w_ready;
  assign nco.code = r_code;
  assign nco.code_valid = r_valid;
endmodule

// File: tb/tb_poly_nco.sv
// tb_poly_nco: randomized bench for poly_nco against a per-request behavioural model
module tb_poly_nco;
  localparam int N = 4, PW = 24, LA = 8, CW = 10;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  poly_nco_if #(.N_CH(N), .PHASE_W(PW), .CODE_W(CW)) nco ();
  poly_nco #(.N_CH(N), .PHASE_W(PW), .LUT_AW(LA), .CODE_W(CW)) dut (.clk(clk), .rst(rst), .nco(nco));

  int vectors = 0, errors = 0;
  int lut [2**LA];
  int m_phase [N];
  int m_acc = 0, m_cnt = 0, m_code = 0;
  bit m_valid = 1'b0, m_live = 1'b0;

  function automatic void check(string nm, logic [31:0] got, logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, got, exp);
    end
  endfunction

  function automatic int wave(int sel, int ph);
    int s, t;
    s = sel;
`ifndef POLY_NCO_MULTI_WAVE_EN
    s = 0;
`endif
    t = (ph >> (PW - CW - 1)) & 1022;
    case (s)
      1: return ph < 2**(PW-1) ? 1023 : 0;
      2: return ph >> (PW - CW);
      3: return ph < 2**(PW-1) ? t : 1023 - t;
      default: return lut[ph >> (PW - LA)];
    endcase
  endfunction

  // model: a request captures nothing up front; channel k is stepped with the inputs seen k+1 edges later
  initial forever begin
    int k;
    @(posedge clk);
    if (rst) begin
      m_live = 1'b1;
      for (int i = 0; i < N; i++) m_phase[i] = 0;
      m_code = 512;
      m_valid = 1'b0;
      m_cnt = 0;
    end else begin
      m_valid = 1'b0;
      if (m_cnt > 0) begin
        k = N + 2 - m_cnt;
        if (k < N && nco.ch_en[k]) begin
          m_phase[k] = (m_phase[k] + int'(nco.fcw[k*PW +: PW])) % (2**PW);
          m_acc += wave(int'(nco.wave_sel[2*k +: 2]), m_phase[k]) - 512;
        end
        m_cnt--;
        if (m_cnt == 0) begin
          m_code = 512 + int'($floor(m_acc / real'(N)));
          m_valid = 1'b1;
        end
      end else if (nco.next_sample) begin
        m_cnt = N + 2;
        m_acc = 0;
      end
    end
  end

  // cycle-by-cycle comparison against the model
  initial forever begin
    @(negedge clk);
    if (m_live) begin
      check("code", nco.code, m_code);
      check("code_valid", nco.code_valid, m_valid);
      check("ready", nco.ready, m_cnt == 0);
    end
  end

  task automatic req();
    nco.next_sample = 1'b1;
    @(negedge clk);
    nco.next_sample = 1'b0;
  endtask

  task automatic wait_valid(output int cyc);
    cyc = 0;
    while (nco.code_valid !== 1'b1 && cyc < 40) begin
      @(negedge clk);
      cyc++;
    end
  endtask

  initial begin
    int cyc, nv, first;
    logic [PW-1:0] f;
    for (int a = 0; a < 2**LA; a++)
      lut[a] = $rtoi($floor(511.0 * $sin(2.0 * 3.14159265358979323846 * a / 256.0) + 0.5)) + 512;
    nco.fcw = '0;
    nco.ch_en = '0;
    nco.wave_sel = '0;
    nco.next_sample = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    check("lut0", lut[0], 512);
    check("lut2", lut[2], 537);
    check("lut10", lut[10], 636);
    check("lut64", lut[64], 1023);
    check("rst_code", nco.code, 512);
    check("rst_ready", nco.ready, 1);
    nco.fcw = {24'd0, 24'd0, 24'h400000, 24'h400000};
    nco.ch_en = 4'b0011;
    req();
    wait_valid(cyc);
    check("latency", cyc, N + 2);
    check("two_voice", nco.code, 767);
    nco.next_sample = 1'b1;
    repeat (3) @(negedge clk);
    nco.next_sample = 1'b0;
    nv = 0;
    first = 0;
    for (int n = 4; n < 16; n++) begin
      @(negedge clk);
      if (nco.code_valid) begin
        nv++;
        if (first == 0) first = n;
        check("busy_code", nco.code, 512);
      end
    end
    check("busy_count", nv, 1);
    check("busy_latency", first, N + 3);
    req();
    wait_valid(cyc);
    check("floor_mix", nco.code, 256);
    req();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("midrst_code", nco.code, 512);
    check("midrst_ready", nco.ready, 1);
    nv = 0;
    repeat (10) begin
      @(negedge clk);
      if (nco.code_valid) nv++;
    end
    check("midrst_novalid", nv, 0);
    req();
    wait_valid(cyc);
    check("after_rst", nco.code, 767);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    nco.fcw = {72'd0, 24'hFF0000};
    nco.ch_en = 4'b0001;
    req();
    wait_valid(cyc);
    check("wrap1", nco.code, 508);
    req();
    wait_valid(cyc);
    check("wrap2", nco.code, 505);
    for (int c = 0; c < 3000; c++) begin
      for (int k = 0; k < N; k++) begin
        case ($urandom_range(3))
          0: f = PW'($urandom);
          1: f = 24'hFFFFFF;
          2: f = PW'($urandom_range(255)) << 16;
          default: f = '0;
        endcase
        nco.fcw[k*PW +: PW] = f;
      end
      nco.ch_en = N'($urandom);
      nco.wave_sel = (2*N)'($urandom);
      nco.next_sample = $urandom_range(2) == 0;
      rst = $urandom_range(299) == 0;
      @(negedge clk);
    end
    rst = 1'b0;
    nco.next_sample = 1'b0;
    repeat (12) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
